// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - ALU control, ALU-op and funct encodings for the execute stage
package alu_exec_unit_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SRL = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_NOR = 4'b0111;
  localparam logic [3:0] FUNCT_SLL = 4'b1000;
  localparam logic [3:0] FUNCT_SRL = 4'b1001;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;

  // Unlisted funct codes fall back to ADD so an illegal R-type still yields a defined result.
  function automatic alu_ctl_e decode_funct(input logic [3:0] funct);
    case (funct)
      FUNCT_ADD: decode_funct = ALU_ADD;
      FUNCT_SUB: decode_funct = ALU_SUB;
      FUNCT_AND: decode_funct = ALU_AND;
      FUNCT_OR:  decode_funct = ALU_OR;
      FUNCT_NOR: decode_funct = ALU_NOR;
      FUNCT_SLL: decode_funct = ALU_SLL;
      FUNCT_SRL: decode_funct = ALU_SRL;
      FUNCT_SLT: decode_funct = ALU_SLT;
      default:   decode_funct = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_add32.sv
// rtl/alu_exec_unit_add32.sv - modular adder used for the PC+4 and branch target paths
module alu_exec_unit_add32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered execute stage: ALU decode, ALU core, PC+4 and branch target
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm_ext,
  output logic             out_valid,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target
);

  alu_ctl_e         ctl_c;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] pc_plus4_c;
  logic [WIDTH-1:0] branch_target_c;
  logic [WIDTH-1:0] imm_shifted;
  logic             slt_c;

  always_comb begin
    ctl_c = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   ctl_c = ALU_ADD;
      ALUOP_SUB:   ctl_c = ALU_SUB;
      ALUOP_OR:    ctl_c = ALU_OR;
      ALUOP_FUNCT: ctl_c = decode_funct(funct);
      default:     ctl_c = ALU_ADD;
    endcase
  end

  // Signed compare rather than the sign of a-b, so overflowing differences still order correctly.
  assign slt_c = ($signed(a) < $signed(b));

  always_comb begin
    result_c = '0;
    case (ctl_c)
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_NOR: result_c = ~(a | b);
      ALU_ADD: result_c = a + b;
      ALU_SUB: result_c = a - b;
      ALU_SLT: result_c = {{(WIDTH-1){1'b0}}, slt_c};
      ALU_SLL: result_c = b << shamt;
      ALU_SRL: result_c = b >> shamt;
      default: result_c = '0;
    endcase
  end

  assign imm_shifted = imm_ext << 2;

  alu_exec_unit_add32 #(.WIDTH(WIDTH)) u_pc_add (
    .a   (pc),
    .b   (WIDTH'(4)),
    .sum (pc_plus4_c)
  );

  alu_exec_unit_add32 #(.WIDTH(WIDTH)) u_branch_add (
    .a   (pc_plus4_c),
    .b   (imm_shifted),
    .sum (branch_target_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_ctl       <= 3'b000;
      result        <= '0;
      zero          <= 1'b1;
      neg           <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_ctl       <= ctl_c;
        result        <= result_c;
        zero          <= (result_c == '0);
        neg           <= result_c[WIDTH-1];
        pc_plus4      <= pc_plus4_c;
        branch_target <= branch_target_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b, pc, imm_ext;
  logic [4:0]  shamt;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic        out_valid;
  logic [2:0]  alu_ctl;
  logic [31:0] result, pc_plus4, branch_target;
  logic        zero, neg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .shamt         (shamt),
    .aluop         (aluop),
    .funct         (funct),
    .pc            (pc),
    .imm_ext       (imm_ext),
    .out_valid     (out_valid),
    .alu_ctl       (alu_ctl),
    .result        (result),
    .zero          (zero),
    .neg           (neg),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] fn, input logic [31:0] va,
                       input logic [31:0] vb, input logic [4:0] sh);
    in_valid = 1'b1;
    aluop = op;
    funct = fn;
    a = va;
    b = vb;
    shamt = sh;
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1; shamt = 5'd3;
    aluop = 2'b00; funct = 4'b0000; pc = 32'h100; imm_ext = 32'h4;
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_ctl", {29'b0, alu_ctl}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd1);
    check("rst_neg", {31'b0, neg}, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'd0);
    check("rst_branch", branch_target, 32'd0);

    rst_n = 1'b1;
    pc = 32'h0000_0010; imm_ext = 32'hFFFF_FFFE;
    drive(2'b00, 4'b0000, 32'h5, 32'h3, 5'd0);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_result", result, 32'h8);
    check("add_ctl", {29'b0, alu_ctl}, 32'b010);
    check("add_zero", {31'b0, zero}, 32'd0);
    check("add_neg", {31'b0, neg}, 32'd0);
    check("pc_plus4", pc_plus4, 32'h14);
    check("branch_target", branch_target, 32'h0C);

    drive(2'b01, 4'b0000, 32'h1234, 32'h1234, 5'd0);
    check("sub_eq_result", result, 32'h0);
    check("sub_eq_zero", {31'b0, zero}, 32'd1);
    check("sub_ctl", {29'b0, alu_ctl}, 32'b110);

    drive(2'b01, 4'b0000, 32'h0, 32'h1, 5'd0);
    check("sub_neg_result", result, 32'hFFFF_FFFF);
    check("sub_neg_flag", {31'b0, neg}, 32'd1);

    drive(2'b11, 4'b0111, 32'hA000_0000, 32'h0000_0005, 5'd0);
    check("ori_result", result, 32'hA000_0005);
    check("ori_ctl", {29'b0, alu_ctl}, 32'b001);

    drive(2'b10, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    check("and_result", result, 32'h00F0_00F0);
    check("and_ctl", {29'b0, alu_ctl}, 32'b000);
    drive(2'b10, 4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    check("or_result", result, 32'hFFF0_FFF0);
    check("or_neg", {31'b0, neg}, 32'd1);
    drive(2'b10, 4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    check("nor_result", result, 32'h000F_000F);
    check("nor_ctl", {29'b0, alu_ctl}, 32'b101);
    drive(2'b10, 4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    check("rsub_result", result, 32'hE100_E100);
    drive(2'b10, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    check("radd_result", result, 32'h00E1_00E0);
    drive(2'b10, 4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
    check("undef_result", result, 32'h00E1_00E0);
    check("undef_ctl", {29'b0, alu_ctl}, 32'b010);

    drive(2'b10, 4'b1010, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0);
    check("slt_neg_pos", result, 32'd1);
    check("slt_ctl", {29'b0, alu_ctl}, 32'b111);
    drive(2'b10, 4'b1010, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0);
    check("slt_pos_neg", result, 32'd0);
    drive(2'b10, 4'b1010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd0);
    check("slt_both_neg", result, 32'd1);
    drive(2'b10, 4'b1010, 32'h1234_5678, 32'h1234_5678, 5'd0);
    check("slt_equal", result, 32'd0);
    check("slt_equal_zero", {31'b0, zero}, 32'd1);

    drive(2'b10, 4'b1000, 32'h0, 32'h8000_0001, 5'd4);
    check("sll_result", result, 32'h0000_0010);
    check("sll_ctl", {29'b0, alu_ctl}, 32'b011);
    drive(2'b10, 4'b1001, 32'h0, 32'h8000_0001, 5'd4);
    check("srl_result", result, 32'h0800_0000);
    check("srl_neg", {31'b0, neg}, 32'd0);
    check("srl_ctl", {29'b0, alu_ctl}, 32'b100);
    drive(2'b10, 4'b1001, 32'h0, 32'h8000_0001, 5'd0);
    check("srl_sh0", result, 32'h8000_0001);
    drive(2'b10, 4'b1000, 32'h0, 32'h8000_0001, 5'd31);
    check("sll_sh31", result, 32'h8000_0000);

    pc = 32'hFFFF_FFFC;
    drive(2'b00, 4'b0000, 32'h1, 32'h1, 5'd0);
    check("pc_wrap", pc_plus4, 32'h0);
    check("branch_wrap", branch_target, 32'hFFFF_FFF8);
    check("wrap_result", result, 32'h2);

    in_valid = 1'b0;
    a = 32'h5555_5555; b = 32'h1111_1111; pc = 32'h4000; aluop = 2'b01;
    step();
    check("hold_valid", {31'b0, out_valid}, 32'd0);
    check("hold_result", result, 32'h2);
    check("hold_ctl", {29'b0, alu_ctl}, 32'b010);
    check("hold_pc_plus4", pc_plus4, 32'h0);
    check("hold_branch", branch_target, 32'hFFFF_FFF8);

    pc = 32'h0000_0100; imm_ext = 32'h0000_0003;
    drive(2'b00, 4'b0000, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check("carry_result", result, 32'h0);
    check("carry_zero", {31'b0, zero}, 32'd1);
    check("branch_fwd", branch_target, 32'h0000_0110);

    rst_n = 1'b0;
    drive(2'b00, 4'b0000, 32'h7, 32'h7, 5'd0);
    check("rst_inflight_valid", {31'b0, out_valid}, 32'd0);
    check("rst_inflight_result", result, 32'd0);
    check("rst_inflight_zero", {31'b0, zero}, 32'd1);
    check("rst_inflight_pc", pc_plus4, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
